// File: rtl/spi_pkg.sv
// Shared types for the SPI transaction arbiter: FSM state encoding,
// default transfer width and requester index type.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_N_REQ  = 4;

  typedef logic [$clog2(SPI_N_REQ)-1:0] spi_req_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_RELEASE = 3'd5,
    ST_GAP     = 3'd6
  } spi_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o
);

  logic found;

  // Two passes: upper half (>= ptr) has priority over the wrapped lower half.
  always_comb begin
    grant_o = '0;
    index_o = '0;
    found   = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_i[j] && (j >= int'(ptr_i))) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        index_o    = IDX_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_i[j] && (j < int'(ptr_i))) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        index_o    = IDX_W'(j);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine among N_REQ requesters.
// Optional watchdog on the engine completion: define SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = SPI_DATA_W,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    err,
  output logic [DATA_W-1:0]       rx_data,
  output logic [N_REQ-1:0]        cs_n,
  output logic                    eng_start,
  output logic [DATA_W-1:0]       eng_data,
  input  logic                    eng_busy,
  input  logic                    eng_done,
  input  logic [DATA_W-1:0]       eng_rx,
  output logic [2:0]              dbg_state
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("spi_txn_arbiter: unsupported parameter set");
  end

  spi_arb_state_t      state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    ptr_d;
  logic [N_REQ-1:0]    sel_oh_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [N_REQ-1:0]    done_q;
  logic [N_REQ-1:0]    cs_n_q;
  logic                eng_start_q;
  logic [DATA_W-1:0]   eng_data_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic [GAP_W-1:0]    gap_q;

  logic [N_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic [DATA_W-1:0]   pick_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .index_o (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    pick_data = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (arb_grant[j]) pick_data = req_data[j*DATA_W +: DATA_W];
    end
  end

  assign ptr_d = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // All outputs are registered; pulses are cleared every cycle unless re-armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sel_oh_q    <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      cs_n_q      <= '1;
      eng_start_q <= 1'b0;
      eng_data_q  <= '0;
      rx_data_q   <= '0;
      gap_q       <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      gnt_q       <= '0;
      done_q      <= '0;
      eng_start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (|req) state_q <= ST_ARB;
        end
        ST_ARB: begin
          if (arb_any) begin
            sel_oh_q   <= arb_grant;
            eng_data_q <= pick_data;
            gnt_q      <= arb_grant;
            ptr_q      <= ptr_d;
            state_q    <= ST_SETUP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          cs_n_q  <= ~sel_oh_q;
          state_q <= ST_START;
        end
        ST_START: begin
          if (!eng_busy) begin
            eng_start_q <= 1'b1;
            state_q     <= ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_q        <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (eng_done) begin
            rx_data_q <= eng_rx;
            state_q   <= ST_RELEASE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            // Abort: free the bus without a completion and keep rx_data.
            cs_n_q  <= '1;
            err_q   <= 1'b1;
            gap_q   <= '0;
            state_q <= ST_GAP;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end
        ST_RELEASE: begin
          cs_n_q  <= '1;
          done_q  <= sel_oh_q;
          gap_q   <= '0;
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_q <= ST_IDLE;
          else                                  gap_q   <= gap_q + GAP_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign cs_n      = cs_n_q;
  assign eng_start = eng_start_q;
  assign eng_data  = eng_data_q;
  assign rx_data   = rx_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: engine model, done/rx scoreboard, scenario tasks.
// Handshake: req is held until the gnt pulse; eng_start/eng_done are 1-cycle pulses.
module tb_spi_txn_arbiter;
  import spi_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 4;
  localparam int TO  = 16;
  localparam int W   = N + DW;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt, done, cs_n;
  logic          err, eng_start, eng_busy, eng_done;
  logic [DW-1:0] rx_data, eng_data, eng_rx;
  logic [2:0]    dbg_state;

  logic          eng_done_m, eng_done_s;
  logic [DW-1:0] eng_rx_m, eng_rx_s;
  logic          eng_auto;
  int            eng_lat;
  logic [DW-1:0] eng_xor;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_e;
  int            checks = 0;
  int            passes = 0;
  int            cs_viol = 0;
  int            err_cnt = 0;

  assign eng_done = eng_done_m | eng_done_s;
  assign eng_rx   = eng_done_s ? eng_rx_s : eng_rx_m;

  spi_txn_arbiter #(
    .N_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .rx_data(rx_data), .cs_n(cs_n),
    .eng_start(eng_start), .eng_data(eng_data), .eng_busy(eng_busy),
    .eng_done(eng_done), .eng_rx(eng_rx), .dbg_state(dbg_state)
  );

  // Clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end

  // Engine model: replies eng_lat cycles after eng_start with eng_data ^ eng_xor
  initial begin
    eng_done_m = 1'b0;
    eng_rx_m   = '0;
    forever begin
      @(posedge clk); #2;
      if (eng_start === 1'b1 && eng_auto) begin
        for (int i = 1; i < eng_lat; i++) begin
          @(posedge clk); #2;
        end
        eng_rx_m   = eng_data ^ eng_xor;
        eng_done_m = 1'b1;
        @(posedge clk); #2;
        eng_done_m = 1'b0;
      end
    end
  end

  // Monitors: chip-select exclusivity, err pulses, done scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && $countones(~cs_n) > 1) cs_viol++;
    if (err === 1'b1) err_cnt++;
    if (done !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_done: got done=%b rx=%h, want no completion", done, rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({done, rx_data} !== mon_e)
          $display("FAIL done_rx: got done=%b rx=%h, want done=%b rx=%h",
                   done, rx_data, mon_e[W-1:DW], mon_e[DW-1:0]);
        else passes++;
        checks++;
        if (cs_n !== '1) $display("FAIL done_cs_high: got cs_n=%b want 1111", cs_n);
        else passes++;
      end
    end
  end

  // Driver helpers
  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    eng_busy = 1'b0;
    eng_auto = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // which: 0 = gnt, 1 = eng_start, 2 = eng_done
  task automatic wait_for(input int which, input string name);
    bit hit = 1'b0;
    int k = 0;
    while (!hit && k < 200) begin
      @(negedge clk);
      k++;
      if ((which == 0 && gnt !== '0) || (which == 1 && eng_start === 1'b1) ||
          (which == 2 && eng_done === 1'b1)) hit = 1'b1;
    end
    checks++;
    if (!hit) $display("FAIL %s: event not seen after %0d cycles", name, k);
    else passes++;
  endtask

  task automatic wait_quiet(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || dbg_state !== ST_IDLE) && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 300) $display("FAIL %s: got %0d pending, state=%0d, want idle and drained", name, exp_q.size(), dbg_state);
    else passes++;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    checks++; if (cs_n !== 4'b1111) $display("FAIL rst_cs_n: got %b want 1111", cs_n); else passes++;
    checks++; if (gnt !== '0) $display("FAIL rst_gnt: got %b want 0000", gnt); else passes++;
    checks++; if (done !== '0) $display("FAIL rst_done: got %b want 0000", done); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passes++;
    checks++; if (eng_start !== 1'b0) $display("FAIL rst_eng_start: got %b want 0", eng_start); else passes++;
    checks++; if (eng_data !== '0) $display("FAIL rst_eng_data: got %h want 00", eng_data); else passes++;
    checks++; if (rx_data !== '0) $display("FAIL rst_rx_data: got %h want 00", rx_data); else passes++;
    checks++; if (dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); else passes++;
  endtask

  task automatic test_single();
    req_data = {8'h44, 8'hD0, 8'h22, 8'h11};
    eng_lat  = 20;
    eng_xor  = 8'hD0 ^ 8'h3C;
    exp_q.push_back({4'b0100, 8'h3C});
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt); else passes++;
    req = '0;
    @(negedge clk);
    checks++; if (cs_n !== 4'b1011) $display("FAIL single_cs_n: got %b want 1011", cs_n); else passes++;
    checks++; if (gnt !== '0) $display("FAIL single_gnt_pulse: got %b want 0000", gnt); else passes++;
    @(negedge clk);
    checks++; if (eng_start !== 1'b1) $display("FAIL single_eng_start: got %b want 1", eng_start); else passes++;
    checks++; if (eng_data !== 8'hD0) $display("FAIL single_eng_data: got %h want d0", eng_data); else passes++;
    wait_for(2, "single_eng_done");
    @(negedge clk);
    checks++; if (done !== '0) $display("FAIL single_done_early: got %b want 0000", done); else passes++;
    @(negedge clk);
    checks++; if (done !== 4'b0100) $display("FAIL single_done_latency: got %b want 0100", done); else passes++;
    wait_quiet("single_quiet");
    checks++; if (rx_data !== 8'h3C) $display("FAIL single_rx_hold: got %h want 3c", rx_data); else passes++;
  endtask

  task automatic test_fairness();
    logic [DW-1:0] fdat [N];
    do_reset();
    fdat[0] = 8'h5A; fdat[1] = 8'hA5; fdat[2] = 8'h3C; fdat[3] = 8'hC3;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = fdat[i];
    eng_lat = 3;
    eng_xor = 8'hFF;
    for (int g = 0; g < 5; g++) exp_q.push_back({4'(1 << (g % N)), ~fdat[g % N]});
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_for(0, "fair_gnt_wait");
      checks++;
      if (gnt !== 4'(1 << (g % N))) $display("FAIL fair_order_%0d: got %b want %b", g, gnt, 4'(1 << (g % N)));
      else passes++;
      if (g == 4) req = '0;
    end
    wait_quiet("fair_quiet");
  endtask

  task automatic test_busy_engine();
    bit bad = 1'b0;
    req_data = {8'h00, 8'h00, 8'h00, 8'h81};
    eng_lat  = 5;
    eng_xor  = 8'h0F;
    eng_busy = 1'b1;
    exp_q.push_back({4'b0001, 8'h8E});
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) $display("FAIL busy_gnt: got %b want 0001", gnt); else passes++;
    req = '0;
    @(negedge clk);
    checks++; if (cs_n !== 4'b1110) $display("FAIL busy_cs_n: got %b want 1110", cs_n); else passes++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (eng_start !== 1'b0 || cs_n !== 4'b1110) bad = 1'b1;
    end
    checks++; if (bad) $display("FAIL busy_hold: got start/cs change while busy, want held"); else passes++;
    eng_busy = 1'b0;
    @(negedge clk);
    checks++; if (eng_start !== 1'b1) $display("FAIL busy_start: got %b want 1", eng_start); else passes++;
    checks++; if (eng_data !== 8'h81) $display("FAIL busy_eng_data: got %h want 81", eng_data); else passes++;
    wait_quiet("busy_quiet");
  endtask

  task automatic test_reset_mid();
    req_data = {8'h00, 8'h00, 8'h77, 8'h42};
    eng_auto = 1'b0;
    req = 4'b0010;
    wait_for(0, "rmid_gnt_wait");
    req = '0;
    wait_for(1, "rmid_start_wait");
    repeat (5) @(negedge clk);
    checks++; if (dbg_state !== ST_WAIT) $display("FAIL rmid_state: got %0d want %0d", dbg_state, ST_WAIT); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (cs_n !== 4'b1111) $display("FAIL rmid_cs_async: got %b want 1111", cs_n); else passes++;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    eng_auto = 1'b1;
    eng_lat  = 4;
    eng_xor  = 8'h00;
    @(negedge clk);
    checks++; if (rx_data !== 8'h00) $display("FAIL rmid_rx: got %h want 00", rx_data); else passes++;
    exp_q.push_back({4'b0001, 8'h42});
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) $display("FAIL rmid_regrant: got %b want 0001", gnt); else passes++;
    req = '0;
    wait_quiet("rmid_quiet");
  endtask

  task automatic test_spurious_done();
    eng_rx_s   = 8'hEE;
    eng_done_s = 1'b1;
    @(negedge clk);
    eng_done_s = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h42) $display("FAIL spur_rx: got %h want 42", rx_data); else passes++;
    checks++; if (dbg_state !== ST_IDLE) $display("FAIL spur_state: got %0d want %0d", dbg_state, ST_IDLE); else passes++;
  endtask

  task automatic test_withdraw();
    logic [N-1:0] gseen = '0;
    req = 4'b0010;
    @(negedge clk);
    checks++; if (dbg_state !== ST_ARB) $display("FAIL wd_arb_state: got %0d want %0d", dbg_state, ST_ARB); else passes++;
    req = '0;
    repeat (3) begin
      @(negedge clk);
      gseen |= gnt;
    end
    checks++; if (gseen !== '0) $display("FAIL withdraw_gnt: got %b want 0000", gseen); else passes++;
    checks++; if (cs_n !== 4'b1111) $display("FAIL withdraw_cs: got %b want 1111", cs_n); else passes++;
    checks++; if (dbg_state !== ST_IDLE) $display("FAIL withdraw_state: got %0d want %0d", dbg_state, ST_IDLE); else passes++;
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_watchdog();
    bit hit = 1'b0;
    int k = 0;
    eng_auto = 1'b0;
    req_data = {8'h00, 8'h99, 8'h00, 8'h24};
    req = 4'b0100;
    wait_for(0, "wdog_gnt_wait");
    req = '0;
    wait_for(1, "wdog_start_wait");
    while (!hit && k < 40) begin
      @(negedge clk);
      k++;
      if (err === 1'b1) hit = 1'b1;
    end
    checks++; if (!hit || k != TO) $display("FAIL wdog_latency: got %0d cycles (seen=%0d) want %0d", k, hit, TO); else passes++;
    checks++; if (cs_n !== 4'b1111) $display("FAIL wdog_cs: got %b want 1111", cs_n); else passes++;
    checks++; if (rx_data !== 8'h42) $display("FAIL wdog_rx: got %h want 42", rx_data); else passes++;
    eng_auto = 1'b1;
    eng_lat  = 2;
    eng_xor  = 8'h00;
    exp_q.push_back({4'b0001, 8'h24});
    wait_quiet("wdog_gap");
    req = 4'b0001;
    wait_for(0, "wdog_next_gnt");
    checks++; if (gnt !== 4'b0001) $display("FAIL wdog_next: got %b want 0001", gnt); else passes++;
    req = '0;
    wait_quiet("wdog_quiet");
  endtask
`endif

  initial begin
    req        = '0;
    req_data   = '0;
    eng_busy   = 1'b0;
    eng_done_s = 1'b0;
    eng_rx_s   = '0;
    eng_auto   = 1'b1;
    eng_lat    = 4;
    eng_xor    = '0;
    rst_n      = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_busy_engine();
    test_reset_mid();
    test_spurious_done();
    test_withdraw();
`ifdef SPI_ARB_TIMEOUT_EN
    test_watchdog();
`endif
    checks++; if (cs_viol != 0) $display("FAIL cs_exclusive: got %0d overlap cycles want 0", cs_viol); else passes++;
    checks++; if (err_cnt != EXP_ERR) $display("FAIL err_count: got %0d want %0d", err_cnt, EXP_ERR); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL sb_drained: got %0d pending want 0", exp_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin transaction arbiter that shares one SPI mode-0 byte engine among up to N_REQ requesters.
- Each requester presents a byte and a request line.
- The arbiter grants one requester, drives its dedicated chip select, starts the engine, and returns the received byte with a completion pulse.
- It sits between client logic (sensor/config managers) and the SPI master engine that generates SCLK/MOSI.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, transfer width in bits
- GAP_CYCLES, 4, clk cycles cs_n stays high between transactions (>=1)
- TIMEOUT_CYCLES, 1024, watchdog limit while waiting for eng_done (used only with SPI_ARB_TIMEOUT_EN)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  request per requester, level
- req_data  in  N_REQ*DATA_W  transmit byte per requester; slice i = bits [i*DATA_W +: DATA_W]
- gnt  out  N_REQ  one-hot, 1-cycle pulse when the request is accepted
- done  out  N_REQ  one-hot, 1-cycle pulse when the transfer completes
- err  out  1  1-cycle pulse on watchdog abort; constant 0 without macro
- rx_data  out  DATA_W  last received byte, held until next completion
- cs_n  out  N_REQ  chip selects, active-low, at most one low
- eng_start  out  1  1-cycle start pulse to engine
- eng_data  out  DATA_W  byte to engine, stable from START until RELEASE
- eng_busy  in  1  engine busy
- eng_done  in  1  engine completion pulse
- eng_rx  in  DATA_W  engine received byte, valid with eng_done

## Operation
- FSM states: IDLE, ARB, SETUP, START, WAIT, RELEASE, GAP.
- **IDLE**
  - Any req bit high -> ARB; else stay.
- **ARB** (1 cycle)
  - Round-robin pick: first set req bit at or after pointer ptr, wrapping modulo N_REQ.
  - Latch index sel and req_data slice into eng_data.
  - Pulse gnt[sel]; ptr <= sel+1 (wrap to 0 after N_REQ-1).
  - If all req bits have dropped, return to IDLE with no gnt.
- **SETUP** (1 cycle)
  - cs_n[sel] <= 0; this is the CS-to-SCLK setup cycle.
- **START**
  - eng_busy=1: wait.
  - eng_busy=0: pulse eng_start, go to WAIT.
- **WAIT**
  - Stay until eng_done.
  - On eng_done: rx_data <= eng_rx, go to RELEASE.
- **RELEASE** (1 cycle)
  - cs_n[sel] <= 1; pulse done[sel].
- **GAP**
  - Count GAP_CYCLES cycles, then IDLE.
- Arbitration and request handling:
  - Requesters hold req until gnt.
  - Dropping req before gnt withdraws it.
  - req held after gnt is a new request, arbitrated fairly.
- eng_done outside WAIT is ignored.

## Timing
- Reset values: state=IDLE, ptr=0, cs_n=all 1, gnt=0, done=0, err=0, eng_start=0, eng_data=0, rx_data=0.
- Reset mid-transfer: cs_n goes high asynchronously; no done is issued.
- Latency from req rising in IDLE:
  - gnt: 2 cycles.
  - cs_n low: 3 cycles.
  - eng_start: 4 cycles if engine idle.
- done is 2 cycles after eng_done, in the same cycle cs_n returns high.
- Minimum CS-high time between transfers: 1 (RELEASE) + GAP_CYCLES + 2 (IDLE, ARB) cycles.
- Simultaneous requests are resolved in ARB only; lines rising after ARB wait for the next round.

## Configuration
- **SPI_ARB_TIMEOUT_EN defined:** a counter of $clog2(TIMEOUT_CYCLES+1) bits runs in WAIT. If it reaches TIMEOUT_CYCLES without eng_done:
  - cs_n[sel] high and err pulse in the same cycle;
  - no done, rx_data unchanged;
  - go to GAP.
- **Undefined:** no counter; WAIT is unbounded; err tied 0.

## Structure
- Shared package spi_pkg holds:
  - arbiter state enum spi_arb_state_t;
  - default DATA_W constant;
  - typedef for the requester index (logic [$clog2(N_REQ)-1:0]).
- Sub-module rr_arbiter is combinational: inputs req and ptr; outputs one-hot grant, index, any.
- The FSM, counters and datapath stay in spi_txn_arbiter.

## Test plan
- **Single request:** req=4'b0100, req_data[2]=8'hD0, engine returns 8'h3C after 20 cycles -> gnt=4'b0100 at +2, cs_n=4'b1011 from +3, eng_data=8'hD0, done[2] pulses, rx_data=8'h3C.
- **Fairness:** req=4'b1111 held through four transfers -> grant order 0,1,2,3, then 0; never two cs_n low.
- **Busy engine:** eng_busy=1 for 10 cycles at START -> eng_start delayed until eng_busy=0, cs_n stays low throughout.
- **Reset:** rst_n asserted during WAIT -> cs_n=4'b1111 immediately, no done; after release, a new req=4'b0001 is granted to requester 0.
- **Watchdog (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16):** eng_done never arrives -> err pulses 16 cycles into WAIT, cs_n high, no done; next request served normally.
- **Withdrawn request:** req=4'b0010 drops in the cycle before ARB -> no gnt, FSM returns to IDLE.
